fp_add_arbiter: RTL
===================

Name: fp_add_arbiter

Overview:
- Shares one `adderr` IEEE-754 single-precision adder instance among NUM_REQ requesters using round-robin arbitration.
- Sequences the adder's timing contract:
  - The mantissa sum is registered inside the adder.
  - The exponent, sign and normalisation paths stay combinational on the operands.
  - Operands are therefore held stable for two cycles, and the result is sampled in the second cycle.
- Returns each result with the requester id on a single valid/ready result port.
- Sits between the NOSE feature-extraction requesters and the shared ALU adder.

Parameters:
- exponent, 8, exponent field width; forwarded to adder
- mantissa, 23, mantissa field width; forwarded to adder
- NUM_REQ, 4, number of requesters; must be 2..8
- ID_W, 2, requester id width; equals clog2(NUM_REQ)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ*(exponent+mantissa+1)  flattened operand A; requester i occupies slice i
- req_b  in  NUM_REQ*(exponent+mantissa+1)  flattened operand B; requester i occupies slice i
- req_ready  out  NUM_REQ  one-hot acceptance; at most one bit high per cycle
- res_valid  out  1  result available
- res_ready  in  1  result consumer accepts
- res_data  out  exponent+mantissa+1  sum from the adder
- res_id  out  ID_W  index of the requester that issued the operation
- busy  out  1  high in any state other than IDLE
- op_count  out  16  completed operations; wraps at 0xFFFF to 0

Behaviour:
- Reset (rst=1 at a clk edge) returns every output and register to its reset value:
  - State goes to IDLE.
  - req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0, op_count=0.
  - Round-robin pointer rr_ptr=0; operand registers op_a=op_b=0.
  - The adder's rst is tied to rst.
  - Reset in any state aborts the in-flight operation; no result is produced for it.
- FSM states:
  - IDLE:
    - If any req_valid is set, the winner is the first set bit searching upward from rst... from rr_ptr, wrapping at NUM_REQ.
    - req_ready[winner]=1 combinationally in that cycle, so the handshake completes in that same cycle.
    - Latch req_a/req_b slice[winner] into op_a/op_b and winner into cur_id.
    - Set rr_ptr = (winner+1) mod NUM_REQ; go to LOAD.
    - With no requests, stay in IDLE.
  - LOAD: op_a/op_b drive the adder; the adder's internal mantissa register captures at the end of this cycle. Go to SETTLE.
  - SETTLE:
    - op_a/op_b are still held; the adder output is valid.
    - At the end of the cycle: res_data <= adder out, res_id <= cur_id, res_valid <= 1, op_count <= op_count+1. Go to DONE.
  - DONE:
    - res_valid=1 and res_data/res_id are held stable until res_ready=1.
    - If res_ready=1 and any req_valid is set, arbitrate exactly as in IDLE in the same cycle; res_valid drops next cycle; go to LOAD.
    - If res_ready=1 and no req_valid is set, res_valid drops next cycle; go to IDLE.
- Timing and throughput:
  - Acceptance cycle T gives res_valid at T+3.
  - Minimum spacing between acceptances is 3 cycles under continuous res_ready.
  - Under result backpressure, req_ready stays 0 for all requesters.
- Operand stability: op_a/op_b change only on an accepted handshake. They are never modified in LOAD, SETTLE, or DONE-without-res_ready.
- Requester rules:
  - A requester must hold req_valid and its operands until it sees req_ready.
  - Deasserting req_valid before grant is legal and loses no state.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- res_data is passed through unmodified; no rounding or exception handling is added, and the adder's arithmetic behaviour is inherited.

Decomposition:
- Shared package fp_alu_pkg holds:
  - FP32 field constants: EXP_W=8, MAN_W=23, WORD_W=32.
  - The state enum {IDLE, LOAD, SETTLE, DONE}.
- Natural sub-module: rr_arbiter (req vector + pointer -> one-hot grant + index), reusable by later multiplier/divider schedulers.
- The `adderr` instance lives inside fp_add_arbiter.

Test Plan:
- Single request: reset; req_valid=4'b0001, req_a[0]=0x3F800000 (1.0), req_b[0]=0x3F800000; res_ready=1.
  - Required: req_ready=0001 in the accept cycle.
  - Required: res_valid 3 cycles later with res_data=0x40000000 (2.0), res_id=0, op_count=1.
- Unequal exponents: requester 2 submits 0x40400000 (3.0) + 0x3F800000 (1.0).
  - Required: res_data=0x40800000 (4.0), res_id=2.
- All four requesters held valid:
  - Required: grants 0,1,2,3,0 in order, 3 cycles apart.
  - Required: each res_id matches its grant, and each res_data matches that requester's operands.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with requester 1 valid.
  - Required: res_data/res_id stable and req_ready=0 throughout.
  - Required: on res_ready=1, requester 1 is granted in that same cycle.
- Reset mid-operation: assert rst in SETTLE.
  - Required: next cycle busy=0, res_valid=0, op_count unchanged-from-reset=0, rr_ptr=0.
  - Required: the next request from requester 3 after requester 0 is idle is granted.
- Counter wrap: preload op_count via 65535 operations (or force).
  - Required: the next completion shows op_count=0.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU schedulers.
//   EXP_W/MAN_W/WORD_W : IEEE-754 single-precision field widths
//   arb_state_e        : operation sequencing states of the adder scheduler
package fp_alu_pkg;
   localparam int EXP_W  = 8;
   localparam int MAN_W  = 23;
   localparam int WORD_W = EXP_W + MAN_W + 1;

   typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} arb_state_e;
endpackage

// File: rtl/adderr.sv
// IEEE-754 adder with a registered mantissa sum.
// The aligned mantissa sum is captured on clk; exponent, sign and
// normalisation are recomputed combinationally from the current operands,
// so a and b must be held for the cycle after the capture edge as well.
// No rounding (alignment truncates), no special-value handling.
//   clk, rst : clock, synchronous active-high reset of the mantissa register
//   a, b     : operands
//   sum      : normalised result, valid one cycle after operands are applied
module adderr #(
   parameter int exponent = 8,
   parameter int mantissa = 23
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [exponent+mantissa:0]   a,
   input  logic [exponent+mantissa:0]   b,
   output logic [exponent+mantissa:0]   sum
);
   localparam int W = exponent + mantissa + 1;

   logic                  a_big;
   logic [W-1:0]          x, y;
   logic [exponent-1:0]   ex, ey, diff, lz;
   logic [mantissa:0]     mx, my, my_sh;
   logic [mantissa+1:0]   msum, msum_q;
   logic [mantissa-1:0]   norm;

   // x is the operand of larger magnitude; it supplies sign and exponent
   assign a_big = a[W-2:0] >= b[W-2:0];
   assign x     = a_big ? a : b;
   assign y     = a_big ? b : a;
   assign ex    = x[W-2:mantissa];
   assign ey    = y[W-2:mantissa];
   assign mx    = {|ex, x[mantissa-1:0]};
   assign my    = {|ey, y[mantissa-1:0]};
   assign diff  = ex - ey;
   assign my_sh = my >> diff;
   assign msum  = (x[W-1] == y[W-1]) ? {1'b0, mx} + {1'b0, my_sh}
                                     : {1'b0, mx} - {1'b0, my_sh};

   always_ff @(posedge clk) begin
      if (rst) msum_q <= '0;
      else     msum_q <= msum;
   end

   // leading-one search: highest set bit wins, giving the left-shift amount
   always_comb begin
      lz = '0;
      for (int i = 0; i <= mantissa; i++)
         if (msum_q[i]) lz = exponent'(mantissa - i);
      norm = mantissa'(msum_q << lz);
      if (msum_q == '0)
         sum = '0;
      else if (msum_q[mantissa+1])
         sum = {x[W-1], ex + exponent'(1), msum_q[mantissa:1]};
      else
         sum = {x[W-1], ex - lz, norm};
   end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping at N.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester
//   any : at least one request present
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);
   logic [IDW-1:0] j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = '0;
      for (int k = 0; k < N; k++) begin
         j = IDW'((int'(ptr) + k) % N);
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = j;
            gnt[j] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one adderr instance among NUM_REQ requesters, round-robin.
// Each accepted operation walks LOAD (mantissa captured) -> SETTLE (result
// sampled) -> DONE (held until res_ready); operands stay frozen throughout.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake, ready is one-hot
//   req_a, req_b        : flattened operands, requester i in slice i
//   res_valid/res_ready : result handshake; res_data, res_id held while stalled
//   busy                : not IDLE
//   op_count            : completed operations, wraps at 16 bits
module fp_add_arbiter
   import fp_alu_pkg::*;
#(
   parameter int exponent = EXP_W,
   parameter int mantissa = MAN_W,
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = 2
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_REQ-1:0]                         req_valid,
   input  logic [NUM_REQ*(exponent+mantissa+1)-1:0]   req_a,
   input  logic [NUM_REQ*(exponent+mantissa+1)-1:0]   req_b,
   output logic [NUM_REQ-1:0]                         req_ready,
   output logic                                       res_valid,
   input  logic                                       res_ready,
   output logic [exponent+mantissa:0]                 res_data,
   output logic [ID_W-1:0]                            res_id,
   output logic                                       busy,
   output logic [15:0]                                op_count
);
   localparam int W = exponent + mantissa + 1;

   arb_state_e                    state, state_nx;
   logic [ID_W-1:0]               rr_ptr, cur_id, win_idx, ptr_nx;
   logic [NUM_REQ-1:0]            gnt;
   logic                          win_any, arb_en, accept;
   logic [NUM_REQ-1:0][W-1:0]     a_arr, b_arr;
   logic [W-1:0]                  op_a, op_b, add_out;

   assign a_arr = req_a;
   assign b_arr = req_b;

   rr_arbiter #(.N(NUM_REQ), .IDW(ID_W)) u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (win_idx),
      .any (win_any)
   );

   adderr #(.exponent(exponent), .mantissa(mantissa)) u_add (
      .clk (clk),
      .rst (rst),
      .a   (op_a),
      .b   (op_b),
      .sum (add_out)
   );

   // arbitration is open in IDLE, and in DONE only once the result drains;
   // gated by rst so no handshake completes on a reset edge
   assign arb_en    = !rst && (state == IDLE || (state == DONE && res_ready));
   assign accept    = arb_en && win_any;
   assign req_ready = arb_en ? gnt : '0;
   assign ptr_nx    = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = LOAD;
         LOAD:    state_nx = SETTLE;
         SETTLE:  state_nx = DONE;
         DONE:    if (res_ready) state_nx = accept ? LOAD : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         op_count  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_a   <= a_arr[win_idx];
            op_b   <= b_arr[win_idx];
            cur_id <= win_idx;
            rr_ptr <= ptr_nx;
         end
         if (state == SETTLE) begin
            res_data  <= add_out;
            res_id    <= cur_id;
            res_valid <= 1'b1;
            op_count  <= op_count + 16'd1;
         end else if (state == DONE && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end
endmodule
